// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: initiator-side load/store controller between execute and the
// sram data-memory responder. One request per handshake, one response back.
//
// Ports
//   clk_i, rst_i         clock (rising edge), synchronous active-high reset
//   req_valid_i/ready_o  request handshake (ready only in IDLE)
//   req_wen_i            1 = store, 0 = load
//   req_addr_i           byte address
//   req_wdata_i          right-aligned store data
//   req_size_i           00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned_i       load zero-extends when 1, sign-extends when 0
//   rsp_valid_o/ready_i  response handshake
//   rsp_rdata_o          load result (0 for stores and errors)
//   rsp_err_o            misaligned / illegal / memory error
//   mem_*                sram request port (strobes, word address, lane data,
//                        byte mask) and read data / response from the sram
//
// State  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for a request; memory strobes driven combinationally
// WAIT   | load issued, counting down the sram read latency
// RESP   | response registered and presented until rsp_ready_i
module lsu_mem_ctrl #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wen_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        mem_ren_o,
  output logic        mem_wen_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_we_mask_o,
  input  logic [31:0] mem_rdata_i,
  input  logic [1:0]  mem_resp_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

  state_t      state;
  logic [2:0]  cnt;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;

  logic [1:0]  a;
  logic        misalign;
  logic        illegal;
  logic        legal;
  logic        issue;
  logic [31:0] shifted;
  logic [31:0] load_val;

  assign a        = req_addr_i[1:0];
  assign misalign = (req_size_i == 2'b01 && a[0]) || (req_size_i == 2'b10 && a != 2'b00);
  assign illegal  = (req_size_i == 2'b11);
  assign legal    = !misalign && !illegal;
  // Only a legal request seen in IDLE outside reset reaches the sram.
  assign issue    = !rst_i && (state == IDLE) && req_valid_i && legal;

  assign req_ready_o = (state == IDLE);
  assign rsp_valid_o = (state == RESP);

  always_comb begin
    mem_ren_o     = issue && !req_wen_i;
    mem_wen_o     = issue && req_wen_i;
    mem_addr_o    = issue ? {req_addr_i[31:2], 2'b00} : 32'h0;
    mem_wdata_o   = 32'h0;
    mem_we_mask_o = 4'h0;
    if (issue && req_wen_i) begin
      case (req_size_i)
        2'b00: begin
          mem_wdata_o   = {4{req_wdata_i[7:0]}};
          mem_we_mask_o = 4'b0001 << a;
        end
        2'b01: begin
          mem_wdata_o   = {2{req_wdata_i[15:0]}};
          mem_we_mask_o = 4'b0011 << a;
        end
        default: begin
          mem_wdata_o   = req_wdata_i;
          mem_we_mask_o = 4'b1111;
        end
      endcase
    end
  end

  // Bring the addressed lane down to bit 0, then extend to 32 bits.
  assign shifted = mem_rdata_i >> {off_q, 3'b000};

  always_comb begin
    case (size_q)
      2'b00:   load_val = uns_q ? {24'h0, shifted[7:0]}   : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = uns_q ? {16'h0, shifted[15:0]}  : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      off_q       <= 2'b00;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      rsp_rdata_o <= 32'h0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            off_q       <= a;
            size_q      <= req_size_i;
            uns_q       <= req_unsigned_i;
            rsp_rdata_o <= 32'h0;
            if (!legal) begin
              rsp_err_o <= 1'b1;
              state     <= RESP;
            end else if (req_wen_i) begin
              rsp_err_o <= 1'b0;
              state     <= RESP;
            end else begin
              rsp_err_o <= 1'b0;
              cnt       <= CNT_INIT;
              state     <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 3'd0) begin
            if (mem_resp_i != 2'b00) begin
              rsp_err_o   <= 1'b1;
              rsp_rdata_o <= 32'h0;
            end else begin
              rsp_err_o   <= 1'b0;
              rsp_rdata_o <= load_val;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_rdata_o <= 32'h0;
            rsp_err_o   <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: two instances (RD_LAT=1 and RD_LAT=3) share one
// request stream; each has its own sram model, scoreboard queue and monitor.
module tb_lsu_mem_ctrl;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          t;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_wen = 1'b0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [1:0]  req_size = 2'b00;

  logic        req_ready [2];
  logic        rsp_valid [2];
  logic        rsp_rdy   [2];
  logic        rsp_err   [2];
  logic        mem_ren   [2];
  logic        mem_wen   [2];
  logic [31:0] rsp_rdata [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic [3:0]  mem_mask  [2];
  logic [1:0]  mem_resp  [2];

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic issuing = 1'b0;
  logic bp_mode = 1'b0;
  logic inj_err = 1'b0;

  logic [31:0] mem [16];
  logic [31:0] pd [2][8];
  logic [1:0]  pr [2][8];

  exp_t q0[$];
  exp_t q1[$];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    lsu_mem_ctrl #(.RD_LAT(g == 0 ? 1 : 3)) u_dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .req_valid_i   (req_valid),
      .req_ready_o   (req_ready[g]),
      .req_wen_i     (req_wen),
      .req_addr_i    (req_addr),
      .req_wdata_i   (req_wdata),
      .req_size_i    (req_size),
      .req_unsigned_i(req_unsigned),
      .rsp_valid_o   (rsp_valid[g]),
      .rsp_ready_i   (rsp_rdy[g]),
      .rsp_rdata_o   (rsp_rdata[g]),
      .rsp_err_o     (rsp_err[g]),
      .mem_ren_o     (mem_ren[g]),
      .mem_wen_o     (mem_wen[g]),
      .mem_addr_o    (mem_addr[g]),
      .mem_wdata_o   (mem_wdata[g]),
      .mem_we_mask_o (mem_mask[g]),
      .mem_rdata_i   (mem_rdata[g]),
      .mem_resp_i    (mem_resp[g])
    );
  end

  function automatic int lat(int g);
    return (g == 0) ? 1 : 3;
  endfunction

  function automatic int nbytes(logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] load_model(logic [31:0] word, logic [1:0] a, logic [1:0] s, logic uns);
    logic [31:0] v;
    int n;
    v = 32'h0;
    n = nbytes(s);
    for (int i = 0; i < n; i++) v[8*i +: 8] = word[8*(int'(a) + i) +: 8];
    if (!uns && n < 4 && v[8*n-1])
      for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic void chk(string name, int g, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d actual=%h required=%h", name, g, cyc, act, req);
    end
  endfunction

  function automatic void sb_push(int g, exp_t e);
    if (g == 0) q0.push_back(e); else q1.push_back(e);
  endfunction
  function automatic int sb_size(int g);
    return (g == 0) ? q0.size() : q1.size();
  endfunction
  function automatic exp_t sb_front(int g);
    return (g == 0) ? q0[0] : q1[0];
  endfunction
  function automatic void sb_pop(int g);
    if (g == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // sram model: read data and response travel down a latency pipeline;
  // off-cycles carry junk data so a wrong capture cycle shows up.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      for (int s = 7; s > 0; s--) begin
        pd[g][s] <= pd[g][s-1];
        pr[g][s] <= pr[g][s-1];
      end
      pd[g][0] <= mem_ren[g] ? mem[mem_addr[g][5:2]] : 32'hDEAD_BEEF;
      pr[g][0] <= (mem_ren[g] && inj_err) ? 2'b10 : 2'b00;
    end
  end

  always_comb begin
    for (int g = 0; g < 2; g++) begin
      mem_rdata[g] = pd[g][lat(g)-1];
      mem_resp[g]  = pr[g][lat(g)-1];
    end
  end

  logic inresp [2] = '{1'b0, 1'b0};
  int   hold   [2] = '{0, 0};
  exp_t mon_e;

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!issuing) chk("strobe_quiet", g, {30'h0, mem_ren[g], mem_wen[g]}, 32'h0);
      if (rst) begin
        inresp[g]  = 1'b0;
        hold[g]    = 0;
        rsp_rdy[g] = 1'b0;
      end else if (rsp_valid[g]) begin
        chk("req_ready_busy", g, {31'h0, req_ready[g]}, 32'h0);
        if (!inresp[g]) begin
          inresp[g] = 1'b1;
          hold[g]   = bp_mode ? 4 : 0;
          if (sb_size(g) == 0) begin
            total++;
            bad++;
            $display("FAIL rsp_unexpected dut%0d cyc=%0d actual=valid required=no response", g, cyc);
          end else begin
            mon_e = sb_front(g);
            chk("rsp_cycle", g, cyc, mon_e.t);
          end
        end
        if (sb_size(g) > 0) begin
          mon_e = sb_front(g);
          chk("rsp_rdata", g, rsp_rdata[g], mon_e.d);
          chk("rsp_err", g, {31'h0, rsp_err[g]}, {31'h0, mon_e.e});
        end
        if (hold[g] > 0) begin
          rsp_rdy[g] = 1'b0;
          hold[g]--;
        end else begin
          rsp_rdy[g] = bp_mode ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
        if (rsp_rdy[g]) begin
          if (sb_size(g) > 0) sb_pop(g);
          inresp[g] = 1'b0;
        end
      end else begin
        inresp[g]  = 1'b0;
        rsp_rdy[g] = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns, input logic inj);
    int n;
    int nb;
    logic [1:0] a;
    logic lg;
    logic [31:0] xw;
    logic [3:0] xm;
    exp_t e;
    n = 0;
    while (!(req_ready[0] && req_ready[1]) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(req_ready[0] && req_ready[1])) begin
      total++;
      bad++;
      $display("FAIL ready_timeout cyc=%0d actual=busy required=idle", cyc);
      return;
    end
    a  = addr[1:0];
    nb = nbytes(size);
    lg = (size != 2'd3) && ((int'(a) % nb) == 0);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata;
    req_size = size; req_unsigned = uns; inj_err = inj; issuing = 1'b1;
    #1;
    xw = 32'h0;
    xm = 4'h0;
    for (int i = 0; i < 4; i++) begin
      xw[8*i +: 8] = wdata[8*(i % nb) +: 8];
      if (i >= int'(a) && i < int'(a) + nb) xm[i] = 1'b1;
    end
    for (int g = 0; g < 2; g++) begin
      chk("mem_ren", g, {31'h0, mem_ren[g]}, {31'h0, lg && !wen});
      chk("mem_wen", g, {31'h0, mem_wen[g]}, {31'h0, lg && wen});
      if (lg) chk("mem_addr", g, mem_addr[g], {addr[31:2], 2'b00});
      if (lg && wen) begin
        chk("mem_wdata", g, mem_wdata[g], xw);
        chk("mem_mask", g, {28'h0, mem_mask[g]}, {28'h0, xm});
      end
      e.t = (lg && !wen) ? cyc + lat(g) + 1 : cyc + 1;
      e.e = lg ? (!wen && inj) : 1'b1;
      e.d = (lg && !wen && !inj) ? load_model(mem[addr[5:2]], a, size, uns) : 32'h0;
      sb_push(g, e);
    end
    if (lg && wen)
      for (int i = 0; i < nb; i++) mem[addr[5:2]][8*(int'(a) + i) +: 8] = wdata[8*i +: 8];
    @(posedge clk); #1;
    req_valid = 1'b0;
    issuing = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_size(0) > 0 || sb_size(1) > 0 || !(req_ready[0] && req_ready[1])) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) begin
      total++;
      bad++;
      $display("FAIL drain_timeout cyc=%0d actual=pending(%0d,%0d) required=empty", cyc, sb_size(0), sb_size(1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [1:0] sz;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;

    // reset with a legal store held on the request port
    rst = 1'b1;
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0004;
    req_wdata = 32'hCAFE_F00D; req_size = 2'd2;
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("rst_req_ready", g, {31'h0, req_ready[g]}, 32'h1);
      chk("rst_rsp_valid", g, {31'h0, rsp_valid[g]}, 32'h0);
      chk("rst_rsp_rdata", g, rsp_rdata[g], 32'h0);
      chk("rst_rsp_err", g, {31'h0, rsp_err[g]}, 32'h0);
      chk("rst_mem_wen", g, {31'h0, mem_wen[g]}, 32'h0);
      chk("rst_mem_addr", g, mem_addr[g], 32'h0);
      chk("rst_mem_wdata", g, mem_wdata[g], 32'h0);
      chk("rst_mem_mask", g, {28'h0, mem_mask[g]}, 32'h0);
    end
    rst = 1'b0;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // byte store, half loads (signed/unsigned), misaligned and illegal size
    issue(1'b1, 32'h8000_0003, 32'h1234_56AB, 2'd0, 1'b0, 1'b0);
    drain();
    mem[4] = 32'h80F1_2345;
    issue(1'b0, 32'h8000_0012, 32'h0, 2'd1, 1'b0, 1'b0);
    issue(1'b0, 32'h8000_0012, 32'h0, 2'd1, 1'b1, 1'b0);
    issue(1'b0, 32'h8000_0006, 32'h0, 2'd2, 1'b0, 1'b0);
    issue(1'b0, 32'h8000_0006, 32'h0, 2'd3, 1'b0, 1'b0);
    drain();

    // backpressure: ready held low 4 cycles; a request offered while busy is ignored
    bp_mode = 1'b1;
    issue(1'b0, 32'h8000_0010, 32'h0, 2'd2, 1'b0, 1'b0);
    n = 0;
    while (!(rsp_valid[0] && rsp_valid[1]) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(rsp_valid[0] && rsp_valid[1])) begin
      total++;
      bad++;
      $display("FAIL bp_wait cyc=%0d actual=no overlap required=both valid", cyc);
    end else begin
      req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0020; req_size = 2'd2;
      req_wdata = 32'h5555_AAAA;
      #1;
      for (int g = 0; g < 2; g++) chk("busy_mem_wen", g, {31'h0, mem_wen[g]}, 32'h0);
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
    drain();
    issue(1'b0, 32'h8000_0010, 32'h0, 2'd2, 1'b0, 1'b1);
    drain();
    bp_mode = 1'b0;

    // reset while both instances are in WAIT
    issue(1'b0, 32'h8000_0014, 32'h0, 2'd2, 1'b0, 1'b0);
    rst = 1'b1;
    q0.delete();
    q1.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int g = 0; g < 2; g++) begin
      chk("midrst_req_ready", g, {31'h0, req_ready[g]}, 32'h1);
      chk("midrst_rsp_valid", g, {31'h0, rsp_valid[g]}, 32'h0);
    end
    repeat (6) @(posedge clk);
    #1;
    issue(1'b0, 32'h8000_0018, 32'h0, 2'd2, 1'b0, 1'b0);
    drain();

    // random traffic
    for (int k = 0; k < 80; k++) begin
      n  = $urandom_range(0, 7);
      sz = (n < 2) ? 2'd0 : (n < 4) ? 2'd1 : (n < 7) ? 2'd2 : 2'd3;
      issue(1'($urandom_range(0, 1)),
            32'h8000_0000 | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3),
            $urandom, sz, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Initiator-side memory access controller that sits between the execute stage and the `sram` data-memory responder. It accepts one load or store per handshake and drives the SRAM request port with a word-aligned address, lane-shifted write data and byte mask. For loads it waits a fixed read latency, then extracts and sign- or zero-extends the addressed byte, half or word. It returns one response per request on a valid/ready port toward writeback, flagging misaligned, illegal or errored accesses.

## Interface

- `RD_LAT`, default 1: cycles from the cycle `mem_ren_o` is sampled high until `mem_rdata_i` is valid; legal range 1..7.
- `clk_i`  in  1  sole clock, rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  controller can accept; high only in IDLE.
- `req_wen_i`  in  1  1 = store, 0 = load.
- `req_addr_i`  in  32  byte address.
- `req_wdata_i`  in  32  store data, right-aligned.
- `req_size_i`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned_i`  in  1  load zero-extends when 1, sign-extends when 0.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  consumer accepts response.
- `rsp_rdata_o`  out  32  load result; 0 for stores and errors.
- `rsp_err_o`  out  1  access error.
- `mem_ren_o`, `mem_wen_o`  out  1 each  SRAM read/write strobe.
- `mem_addr_o`  out  32  `{req_addr_i[31:2], 2'b00}`.
- `mem_wdata_o`  out  32  lane-shifted store data.
- `mem_we_mask_o`  out  4  byte-lane write mask.
- `mem_rdata_i`  in  32  SRAM read data (registered in the SRAM).
- `mem_resp_i`  in  2  SRAM response; 00 = OK, anything else = error.

## Operation

- **States:** IDLE, WAIT (load latency), RESP (holding response). Reset enters IDLE.
- **Accept:** in IDLE, when `req_valid_i & req_ready_o` (cycle T), the request is registered (offset `a = addr[1:0]`, size, unsigned, wen).
- **Legality:**
  - Misaligned: half with `a[0]=1`, or word with `a!=0`.
  - Size 11 is illegal.
  - A misaligned or illegal request issues no memory access and goes to RESP with `rsp_err_o=1` and `rsp_rdata_o=0`.
- **Memory strobes:** driven combinationally in IDLE only, for legal requests only:
  - `mem_ren_o = req_valid_i & ~req_wen_i`
  - `mem_wen_o = req_valid_i & req_wen_i`
  - All `mem_*` outputs are forced to 0 while `rst_i` is high or the state is not IDLE.
- **Store:**
  - Byte: `mem_wdata_o = {4{wdata[7:0]}}`, mask `4'b0001 << a`.
  - Half: `mem_wdata_o = {2{wdata[15:0]}}`, mask `4'b0011 << a`.
  - Word: data unchanged, mask `4'b1111`.
  - The write completes at the T edge. The next state is RESP with `rsp_rdata_o=0` and `rsp_err_o=0`.
- **Load:** the next state is WAIT with counter = `RD_LAT-1`. The counter decrements each WAIT cycle. On the cycle the counter is 0:
  - `mem_rdata_i` is shifted right by `8*a`.
  - The low 8 or 16 bits are extended per `req_unsigned_i`; a word passes unchanged.
  - The result is captured into `rsp_rdata_o`.
  - `rsp_err_o` captures `mem_resp_i != 2'b00`; on error, `rsp_rdata_o` is forced to 0.
  - The next state is RESP.
- **RESP:** `rsp_valid_o=1`, data and error held stable until `rsp_ready_i`. On handshake the next state is IDLE. A new request is not accepted in the same cycle.
- **Reset mid-operation:** any state returns to IDLE at the reset edge. The in-flight response is discarded and never presented.

## Timing

- **Reset values:** `req_ready_o=1` (IDLE), `rsp_valid_o=0`, `rsp_rdata_o=0`, `rsp_err_o=0`, all `mem_*` outputs 0, counter 0.
- **Store / error:** accept at T, `rsp_valid_o` high from T+1. Minimum occupancy is 2 cycles.
- **Load:** accept at T, WAIT spans T+1..T+RD_LAT, `rsp_valid_o` high from T+RD_LAT+1. With RD_LAT=1, the response is at T+2.
- **Throughput:** one request per 2 cycles (store) or RD_LAT+2 cycles (load) with `rsp_ready_i` held high.
- **Backpressure:** `rsp_ready_i` low stretches RESP indefinitely; `req_ready_o` stays 0 throughout.
- **Outputs:** `req_ready_o` and `rsp_valid_o` are pure state decodes with no combinational path from `rsp_ready_i`.

## Test plan

- **Reset:** assert `rst_i` 2 cycles -> all outputs at their reset values, `req_ready_o=1`. Then drive `req_valid_i=0` 5 cycles -> `mem_ren_o` and `mem_wen_o` stay 0.
- **Byte store:** addr 0x8000_0003, data 0x1234_56AB, size 00 -> at T `mem_wen_o=1`, `mem_addr_o=0x8000_0000`, `mem_wdata_o=0xABABABAB`, mask 1000; T+1 `rsp_valid_o=1`, `rsp_err_o=0`.
- **Half loads:** memory word 0x80F1_2345 at 0x8000_0010; load half at 0x...12, signed -> `rsp_rdata_o=0xFFFF80F1` at T+2 (RD_LAT=1). The same load with `req_unsigned_i=1` -> 0x0000_80F1.
- **Misaligned:** word load at 0x8000_0006 -> no `mem_ren_o` pulse; T+1 `rsp_valid_o=1`, `rsp_err_o=1`, `rsp_rdata_o=0`. Repeat with size 11 -> same result.
- **Backpressure and latency:** RD_LAT=3, `rsp_ready_i=0` for 4 cycles after `rsp_valid_o` rises -> response appears at T+4 and holds stable with `req_ready_o=0`. Forcing `mem_resp_i=2'b10` on the capture cycle -> `rsp_err_o=1`, data 0.
- **Reset mid-operation:** assert `rst_i` during WAIT -> next cycle IDLE, `rsp_valid_o` never rises for that load. A following word load returns the correct data.
